// File: rtl/alu_op_sequencer.sv
// Multicycle ALU front-end: accepts one request at a time, drives an external
// combinational ALU from registered operands, and returns the captured result.
// Multiply is done by shift-add, iterating the ALU in add mode WIDTH times.
module alu_op_sequencer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic             req_mul,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_srcA,
  output logic [WIDTH-1:0] alu_srcB,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StExec, StMul, StResp} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);
  localparam logic [2:0]       OpAdd   = 3'b000;

  state_e           r_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;
  logic             r_rsp_valid;
  logic             r_busy;
  logic             r_req_ready;

  logic [WIDTH-1:0] w_src_a;
  logic [WIDTH-1:0] w_src_b;
  logic [2:0]       w_op;

  // ALU operand steering; idle and response states present zeros to the ALU.
  always_comb begin
    w_src_a = '0;
    w_src_b = '0;
    w_op    = '0;
    case (r_state)
      StExec: begin
        w_src_a = r_op_a;
        w_src_b = r_op_b;
        w_op    = r_op;
      end
      StMul: begin
        // Partial product: add the shifted multiplicand when the current multiplier bit is set.
        w_src_a = r_acc;
        w_src_b = r_op_b[0] ? r_op_a : '0;
        w_op    = OpAdd;
      end
      default: ;
    endcase
  end

  // Control FSM with registered handshake/status outputs and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op         <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_req_ready  <= 1'b1;
    end else begin
      case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_op_a      <= req_a;
            r_op_b      <= req_b;
            r_op        <= req_op;
            r_busy      <= 1'b1;
            r_req_ready <= 1'b0;
            if (req_mul) begin
              r_acc   <= '0;
              r_cnt   <= '0;
              r_state <= StMul;
            end else begin
              r_state <= StExec;
            end
          end
        end
        StExec: begin
          r_rsp_result <= alu_result;
          r_rsp_zero   <= alu_zero;
          r_rsp_valid  <= 1'b1;
          r_state      <= StResp;
        end
        StMul: begin
          r_acc  <= alu_result;
          r_op_a <= r_op_a << 1;
          r_op_b <= r_op_b >> 1;
          r_cnt  <= r_cnt + CNT_W'(1);
          // No early exit: always run the full WIDTH iterations.
          if (r_cnt == LastCnt) begin
            r_rsp_result <= alu_result;
            r_rsp_zero   <= alu_zero;
            r_rsp_valid  <= 1'b1;
            r_state      <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign alu_srcA   = w_src_a;
  assign alu_srcB   = w_src_b;
  assign alu_op     = w_op;
  assign req_ready  = r_req_ready;
  assign busy       = r_busy;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;

endmodule
